br_fifo_wr_arb: RTL

Two-requester write arbiter and credit controller for the 4x32 broadcast FIFO. Grants the single FIFO write port to one of two bursting requesters at a time, round-robin at burst boundaries, so bursts never interleave in the FIFO. It keeps its own occupancy count from accepted writes and observed reads, and never issues a write the FIFO cannot absorb. Sits between the two broadcast producers and the FIFO, in the FIFO's single clock domain.

---
 rtl/br_fifo_wr_arb.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/br_fifo_wr_arb.sv
// Write-port arbiter and credit controller for the 4x32 broadcast FIFO.
// Round-robin between two bursting requesters at burst boundaries, with a local occupancy count.
module br_fifo_wr_arb #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int PTR   = 2
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  input  logic             last0,
  output logic             ack0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  input  logic             last1,
  output logic             ack1,
  output logic             fifo_wrreq,
  output logic [WIDTH-1:0] fifo_data,
  input  logic             fifo_wrfull,
  input  logic             fifo_rdreq,
  input  logic             fifo_rdempty,
  output logic [1:0]       grant,
  output logic [PTR:0]     used,
  output logic             ovf_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BUSY0 = 2'b01,
    BUSY1 = 2'b10
  } state_t;

  localparam logic [PTR:0] FULL_CNT = (PTR+1)'(DEPTH);
  localparam logic [PTR:0] ONE_CNT  = (PTR+1)'(1);

  state_t           r_state;
  state_t           w_next;
  logic             r_rr;
  logic [PTR:0]     r_used;
  logic             r_wrreq;
  logic [WIDTH-1:0] r_data;
  logic             r_ovf;
  logic             w_room;
  logic             w_ack0;
  logic             w_ack1;
  logic             w_inc;
  logic             w_dec;

  assign w_room = (r_used < FULL_CNT);
  assign w_inc  = w_ack0 | w_ack1;
  assign w_dec  = fifo_rdreq & ~fifo_rdempty;

  // Next-state and acks; acks are masked during reset so no word is lost to an abandoned burst.
  always_comb begin
    w_next = r_state;
    w_ack0 = 1'b0;
    w_ack1 = 1'b0;
    case (r_state)
      IDLE: begin
        if (req0 && req1) begin
          w_next = r_rr ? BUSY1 : BUSY0;
        end else if (req0) begin
          w_next = BUSY0;
        end else if (req1) begin
          w_next = BUSY1;
        end else begin
          w_next = IDLE;
        end
      end
      BUSY0: begin
        w_ack0 = req0 & w_room & ~aclr;
        if (w_ack0 && last0) begin
          w_next = IDLE;
        end else begin
          w_next = BUSY0;
        end
      end
      BUSY1: begin
        w_ack1 = req1 & w_room & ~aclr;
        if (w_ack1 && last1) begin
          w_next = IDLE;
        end else begin
          w_next = BUSY1;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // State, round-robin pointer and write-port registers.
  always_ff @(posedge clk) begin
    if (aclr) begin
      r_state <= IDLE;
      r_rr    <= 1'b0;
      r_wrreq <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_next;
      if (w_ack0 && last0) begin
        r_rr <= 1'b1;
      end else if (w_ack1 && last1) begin
        r_rr <= 1'b0;
      end
      r_wrreq <= w_inc;
      if (w_ack0) begin
        r_data <= data0;
      end else if (w_ack1) begin
        r_data <= data1;
      end
    end
  end

  // Occupancy count: a simultaneous accept and read cancel; reads at zero are ignored.
  always_ff @(posedge clk) begin
    if (aclr) begin
      r_used <= '0;
    end else if (w_inc && !w_dec && w_room) begin
      r_used <= r_used + ONE_CNT;
    end else if (!w_inc && w_dec && (r_used != '0)) begin
      r_used <= r_used - ONE_CNT;
    end
  end

  // Sticky overflow monitor.
  always_ff @(posedge clk) begin
    if (aclr) begin
      r_ovf <= 1'b0;
    end else if (r_wrreq && fifo_wrfull) begin
      r_ovf <= 1'b1;
    end
  end

  assign ack0       = w_ack0;
  assign ack1       = w_ack1;
  assign fifo_wrreq = r_wrreq;
  assign fifo_data  = r_data;
  assign grant      = r_state;
  assign used       = r_used;
  assign ovf_err    = r_ovf;

endmodule
